// File: rtl/cp0_trap_seq_if.sv
// CP0 register port bundle between the trap sequencer (master) and the CP0 register file (slave).
// Read data is combinational from the currently driven number/select.
interface cp0_trap_seq_if;
    logic [4:0]  cp0_num;
    logic [2:0]  cp0_sel;
    logic [31:0] cp0_wdata;
    logic        cp0_wr;
    logic        cp0_rd;
    logic [2:0]  cp0_op;
    logic [31:0] cp0_rdata;

    modport master (
        output cp0_num,
        output cp0_sel,
        output cp0_wdata,
        output cp0_wr,
        output cp0_rd,
        output cp0_op,
        input  cp0_rdata
    );

    modport slave (
        input  cp0_num,
        input  cp0_sel,
        input  cp0_wdata,
        input  cp0_wr,
        input  cp0_rd,
        input  cp0_op,
        output cp0_rdata
    );
endinterface

// File: rtl/cp0_trap_seq.sv
// Trap/return sequencer: owns the CP0 port, passes pipeline mfc0/mtc0 through when idle, and runs
// the EPC/CAUSE/STATUS sequence for exceptions, interrupts and eret before redirecting fetch.
module cp0_trap_seq #(
    parameter logic [31:0] VECTOR     = 32'h0000_3000,
    parameter logic [31:0] BEV_VECTOR = 32'hBFC0_0380
) (
    input  logic                  clk,
    input  logic                  rst,
    cp0_trap_seq_if.master        cp0,
    input  logic [4:0]            pipe_num_i,
    input  logic [2:0]            pipe_sel_i,
    input  logic [31:0]           pipe_wdata_i,
    input  logic                  pipe_wr_i,
    input  logic                  pipe_rd_i,
    output logic [31:0]           pipe_rdata_o,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exc_code_i,
    input  logic [31:0]           exc_pc_i,
    input  logic                  eret_valid_i,
    input  logic [5:0]            int_req_i,
    output logic                  trap_ack_o,
    output logic                  busy_o,
    output logic                  flush_o,
    output logic                  redirect_valid_o,
    output logic [31:0]           redirect_pc_o
);

    localparam logic [2:0] COP_OP_MV    = 3'd0;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_ERROREPC = 5'd30;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_EPC,
        S_T_CAUSE,
        S_T_STATUS,
        S_T_REDIR,
        S_E_RD,
        S_E_STATUS,
        S_E_REDIR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] status_sh_q, status_sh_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] pc_q, pc_d;
    logic [5:0]  int_q, int_d;
    logic [31:0] target_q, target_d;

    logic [4:0]  num_c;
    logic [2:0]  sel_c;
    logic [31:0] wdata_c;
    logic        wr_c;
    logic        rd_c;
    logic        trap_ack_c;
    logic        busy_c;
    logic        flush_c;
    logic        redir_valid_c;
    logic [31:0] redir_pc_c;
    logic        int_take;

    // Interrupt is taken only with IE set, EXL/ERL clear and an unmasked line active.
    assign int_take = status_sh_q[0] & ~status_sh_q[1] & ~status_sh_q[2]
                    & (|(int_req_i & status_sh_q[15:10]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            status_sh_q <= '0;
            code_q      <= '0;
            pc_q        <= '0;
            int_q       <= '0;
            target_q    <= '0;
        end else begin
            state_q     <= state_d;
            status_sh_q <= status_sh_d;
            code_q      <= code_d;
            pc_q        <= pc_d;
            int_q       <= int_d;
            target_q    <= target_d;
        end
    end

    // Outputs are forced low while reset is held, even though IDLE would otherwise drive a STATUS read.
    always_comb begin
        state_d       = state_q;
        status_sh_d   = status_sh_q;
        code_d        = code_q;
        pc_d          = pc_q;
        int_d         = int_q;
        target_d      = target_q;
        num_c         = '0;
        sel_c         = '0;
        wdata_c       = '0;
        wr_c          = 1'b0;
        rd_c          = 1'b0;
        trap_ack_c    = 1'b0;
        busy_c        = 1'b0;
        flush_c       = 1'b0;
        redir_valid_c = 1'b0;
        redir_pc_c    = '0;

        if (!rst) begin
            unique case (state_q)
                S_IDLE: begin
                    if (exc_valid_i) begin
                        trap_ack_c = 1'b1;
                        code_d     = exc_code_i;
                        pc_d       = exc_pc_i;
                        int_d      = int_req_i;
                        state_d    = S_T_EPC;
                    end else if (int_take) begin
                        code_d  = 5'd0;
                        pc_d    = exc_pc_i;
                        int_d   = int_req_i;
                        state_d = S_T_EPC;
                    end else if (eret_valid_i) begin
                        trap_ack_c = 1'b1;
                        state_d    = S_E_RD;
                    end else if (pipe_wr_i || pipe_rd_i) begin
                        num_c   = pipe_num_i;
                        sel_c   = pipe_sel_i;
                        wdata_c = pipe_wdata_i;
                        wr_c    = pipe_wr_i;
                        rd_c    = pipe_rd_i;
                        if (pipe_wr_i && pipe_num_i == REG_STATUS && pipe_sel_i == 3'd0) begin
                            status_sh_d = pipe_wdata_i;
                        end
                    end else begin
                        num_c       = REG_STATUS;
                        rd_c        = 1'b1;
                        status_sh_d = cp0.cp0_rdata;
                    end
                end
                S_T_EPC: begin
                    busy_c = 1'b1;
                    if (!status_sh_q[1]) begin
                        num_c   = REG_EPC;
                        wdata_c = pc_q;
                        wr_c    = 1'b1;
                    end
                    state_d = S_T_CAUSE;
                end
                S_T_CAUSE: begin
                    busy_c  = 1'b1;
                    num_c   = REG_CAUSE;
                    wdata_c = {16'b0, int_q, 2'b0, 1'b0, code_q, 2'b0};
                    wr_c    = 1'b1;
                    state_d = S_T_STATUS;
                end
                S_T_STATUS: begin
                    busy_c      = 1'b1;
                    num_c       = REG_STATUS;
                    wdata_c     = status_sh_q | 32'h2;
                    wr_c        = 1'b1;
                    status_sh_d = status_sh_q | 32'h2;
                    state_d     = S_T_REDIR;
                end
                S_T_REDIR: begin
                    busy_c        = 1'b1;
                    flush_c       = 1'b1;
                    redir_valid_c = 1'b1;
                    redir_pc_c    = status_sh_q[22] ? BEV_VECTOR : VECTOR;
                    state_d       = S_IDLE;
                end
                S_E_RD: begin
                    busy_c   = 1'b1;
                    num_c    = status_sh_q[2] ? REG_ERROREPC : REG_EPC;
                    rd_c     = 1'b1;
                    target_d = cp0.cp0_rdata;
                    state_d  = S_E_STATUS;
                end
                S_E_STATUS: begin
                    busy_c      = 1'b1;
                    num_c       = REG_STATUS;
                    wdata_c     = status_sh_q & ~(status_sh_q[2] ? 32'h4 : 32'h2);
                    wr_c        = 1'b1;
                    status_sh_d = status_sh_q & ~(status_sh_q[2] ? 32'h4 : 32'h2);
                    state_d     = S_E_REDIR;
                end
                S_E_REDIR: begin
                    busy_c        = 1'b1;
                    flush_c       = 1'b1;
                    redir_valid_c = 1'b1;
                    redir_pc_c    = target_q;
                    state_d       = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign cp0.cp0_num       = num_c;
    assign cp0.cp0_sel       = sel_c;
    assign cp0.cp0_wdata     = wdata_c;
    assign cp0.cp0_wr        = wr_c;
    assign cp0.cp0_rd        = rd_c;
    assign cp0.cp0_op        = COP_OP_MV;
    assign pipe_rdata_o      = cp0.cp0_rdata;
    assign trap_ack_o        = trap_ack_c;
    assign busy_o            = busy_c;
    assign flush_o           = flush_c;
    assign redirect_valid_o  = redir_valid_c;
    assign redirect_pc_o     = redir_pc_c;

endmodule

// File: tb/tb_cp0_trap_seq.sv
// Bench for cp0_trap_seq: CP0 register file model, table of directed trap cases, hand-written
// multi-cycle corners and randomized traps predicted from the architectural trap rules.
module tb_cp0_trap_seq;

    localparam int K_EXC  = 0;
    localparam int K_INT  = 1;
    localparam int K_ERET = 2;
    localparam int LAT_ENTRY = 4;
    localparam int LAT_ERET  = 3;

    typedef struct {
        int          kind;
        logic [31:0] status;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [5:0]  intReq;
        logic [31:0] epcPre;
        logic [31:0] errPre;
    } stim_t;

    typedef struct {
        bit               accept;
        bit               ack;
        int               nWr;
        logic [2:0][7:0]  wReg;
        logic [2:0][31:0] wData;
        logic [31:0]      redir;
        int               lat;
        bit               flushOk;
    } resp_t;

    typedef struct {
        stim_t s;
        resp_t r;
    } vec_t;

    typedef struct packed {
        logic [4:0]  num;
        logic [2:0]  sel;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  pipeNum = '0;
    logic [2:0]  pipeSel = '0;
    logic [31:0] pipeWdata = '0;
    logic        pipeWr = 1'b0;
    logic        pipeRd = 1'b0;
    logic [31:0] pipeRdata;
    logic        excValid = 1'b0;
    logic [4:0]  excCode = '0;
    logic [31:0] excPc = '0;
    logic        eretValid = 1'b0;
    logic [5:0]  intReq = '0;
    logic        trapAck;
    logic        busy;
    logic        flush;
    logic        redirectValid;
    logic [31:0] redirectPc;

    logic [31:0] cp0Regs [256] = '{default: '0};
    wr_t         wrLog [$];

    int checks = 0;
    int errors = 0;

    cp0_trap_seq_if cpIf ();

    cp0_trap_seq dut (
        .clk              (clk),
        .rst              (rst),
        .cp0              (cpIf),
        .pipe_num_i       (pipeNum),
        .pipe_sel_i       (pipeSel),
        .pipe_wdata_i     (pipeWdata),
        .pipe_wr_i        (pipeWr),
        .pipe_rd_i        (pipeRd),
        .pipe_rdata_o     (pipeRdata),
        .exc_valid_i      (excValid),
        .exc_code_i       (excCode),
        .exc_pc_i         (excPc),
        .eret_valid_i     (eretValid),
        .int_req_i        (intReq),
        .trap_ack_o       (trapAck),
        .busy_o           (busy),
        .flush_o          (flush),
        .redirect_valid_o (redirectValid),
        .redirect_pc_o    (redirectPc)
    );

    always #5 clk = ~clk;

    // CP0 register file model: combinational read, write on the rising edge, every write logged.
    assign cpIf.cp0_rdata = cp0Regs[{cpIf.cp0_num, cpIf.cp0_sel}];

    always @(posedge clk) begin
        if (!rst && cpIf.cp0_wr) begin
            cp0Regs[{cpIf.cp0_num, cpIf.cp0_sel}] <= cpIf.cp0_wdata;
            wrLog.push_back({cpIf.cp0_num, cpIf.cp0_sel, cpIf.cp0_wdata});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic stim_t mkS(input int kind, input logic [31:0] status, input logic [4:0] code,
                                  input logic [31:0] pc, input logic [5:0] ir,
                                  input logic [31:0] epcPre, input logic [31:0] errPre);
        stim_t s;
        s.kind = kind; s.status = status; s.code = code; s.pc = pc;
        s.intReq = ir; s.epcPre = epcPre; s.errPre = errPre;
        return s;
    endfunction

    function automatic resp_t mkR(input bit acc, input bit ack, input int n,
                                  input logic [4:0] n0, input logic [31:0] d0,
                                  input logic [4:0] n1, input logic [31:0] d1,
                                  input logic [4:0] n2, input logic [31:0] d2,
                                  input logic [31:0] redir, input int lat);
        resp_t r;
        r.accept = acc; r.ack = ack; r.nWr = n;
        r.wReg[0] = {n0, 3'b000}; r.wData[0] = d0;
        r.wReg[1] = {n1, 3'b000}; r.wData[1] = d1;
        r.wReg[2] = {n2, 3'b000}; r.wData[2] = d2;
        r.redir = redir; r.lat = lat; r.flushOk = 1'b1;
        return r;
    endfunction

    // Reference model: what the trap rules say should reach CP0 and the fetch unit.
    function automatic resp_t predict(input stim_t s);
        resp_t r;
        bit ie, exl, erl, bev, take;
        logic [31:0] wd [3];
        logic [4:0]  wn [3];
        int n;
        ie  = s.status[0];
        exl = s.status[1];
        erl = s.status[2];
        bev = s.status[22];
        n = 0;
        wd = '{default: '0};
        wn = '{default: '0};
        r = mkR(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        if (s.kind == K_ERET) begin
            wn[0] = 12;
            wd[0] = erl ? (s.status & 32'hFFFF_FFFB) : (s.status & 32'hFFFF_FFFD);
            r = mkR(1, 1, 1, wn[0], wd[0], 0, 0, 0, 0, erl ? s.errPre : s.epcPre, LAT_ERET);
        end else begin
            take = (s.kind == K_EXC) ||
                   (ie && !exl && !erl && ((s.intReq & s.status[15:10]) != 0));
            if (take) begin
                if (!exl) begin
                    wn[n] = 14; wd[n] = s.pc; n++;
                end
                wn[n] = 13;
                wd[n] = (32'(s.intReq) * 1024) + ((s.kind == K_EXC) ? 32'(s.code) * 4 : 32'd0);
                n++;
                wn[n] = 12; wd[n] = s.status | 32'h2; n++;
                r = mkR(1, s.kind == K_EXC, n, wn[0], wd[0], wn[1], wd[1], wn[2], wd[2],
                        bev ? 32'hBFC0_0380 : 32'h0000_3000, LAT_ENTRY);
            end
        end
        return r;
    endfunction

    task automatic pipeWrite(input logic [4:0] n, input logic [31:0] d);
        @(negedge clk);
        pipeNum = n; pipeSel = 3'd0; pipeWdata = d; pipeWr = 1'b1;
        @(negedge clk);
        pipeNum = '0; pipeWdata = '0; pipeWr = 1'b0;
    endtask

    task automatic waitSig(input int which, input int maxCyc, output bit found, output int cnt);
        found = 1'b0;
        cnt = -1;
        for (int c = 0; c < maxCyc; c++) begin
            #1;
            if ((which == 0 && redirectValid) || (which == 1 && trapAck)) begin
                found = 1'b1;
                cnt = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input stim_t s, output resp_t o);
        int start;
        pipeWrite(14, s.epcPre);
        pipeWrite(30, s.errPre);
        pipeWrite(12, s.status);
        @(negedge clk);
        start = wrLog.size();
        o = mkR(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        excValid  = (s.kind == K_EXC);
        eretValid = (s.kind == K_ERET);
        excCode   = s.code;
        excPc     = s.pc;
        intReq    = s.intReq;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            if (trapAck) o.ack = 1'b1;
            if (busy || trapAck) o.accept = 1'b1;
            if (redirectValid && o.lat < 0) begin
                o.lat   = cyc;
                o.redir = redirectPc;
            end
            if (flush !== redirectValid) o.flushOk = 1'b0;
            @(negedge clk);
            if (cyc == 0) begin
                excValid = 1'b0; eretValid = 1'b0; intReq = '0;
            end
        end
        o.nWr = wrLog.size() - start;
        for (int k = 0; k < 3; k++) begin
            if (k < o.nWr) begin
                o.wReg[k]  = {wrLog[start + k].num, wrLog[start + k].sel};
                o.wData[k] = wrLog[start + k].data;
            end else begin
                o.wReg[k]  = 8'hFF;
                o.wData[k] = 32'hFFFF_FFFF;
            end
        end
    endtask

    task automatic checkOutput(input string name, input resp_t exp, input resp_t obs);
        check({name, ".accept"}, 64'(obs.accept), 64'(exp.accept));
        check({name, ".ack"}, 64'(obs.ack), 64'(exp.ack));
        check({name, ".nwr"}, 64'(obs.nWr), 64'(exp.nWr));
        for (int k = 0; k < 3; k++) begin
            if (k < exp.nWr) begin
                check($sformatf("%s.wr%0d", name, k), {24'b0, obs.wReg[k], obs.wData[k]},
                      {24'b0, exp.wReg[k], exp.wData[k]});
            end
        end
        if (exp.accept) begin
            check({name, ".redir_pc"}, 64'(obs.redir), 64'(exp.redir));
            check({name, ".latency"}, 64'(obs.lat), 64'(exp.lat));
        end
        check({name, ".flush"}, 64'(obs.flushOk), 64'(1'b1));
    endtask

    vec_t  vecs [8];
    stim_t s;
    resp_t obs;
    resp_t exp;
    bit    found;
    int    cnt;
    logic [31:0] causeBefore;
    logic [4:0]  codes [4] = '{5'd8, 5'd9, 5'd10, 5'd12};

    initial begin
        vecs[0] = '{s: mkS(K_EXC, 32'h1, 8, 32'h100, 0, 0, 0),
                    r: mkR(1, 1, 3, 14, 32'h100, 13, 32'h20, 12, 32'h3, 32'h3000, LAT_ENTRY)};
        vecs[1] = '{s: mkS(K_INT, 32'h401, 0, 32'h200, 6'h1, 0, 0),
                    r: mkR(1, 0, 3, 14, 32'h200, 13, 32'h400, 12, 32'h403, 32'h3000, LAT_ENTRY)};
        vecs[2] = '{s: mkS(K_INT, 32'h403, 0, 32'h240, 6'h1, 0, 0),
                    r: mkR(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1)};
        vecs[3] = '{s: mkS(K_EXC, 32'h0040_0003, 9, 32'h300, 0, 32'h55, 0),
                    r: mkR(1, 1, 2, 13, 32'h24, 12, 32'h0040_0003, 0, 0, 32'hBFC0_0380, LAT_ENTRY)};
        vecs[4] = '{s: mkS(K_ERET, 32'h6, 0, 0, 0, 32'h1111, 32'h2000),
                    r: mkR(1, 1, 1, 12, 32'h2, 0, 0, 0, 0, 32'h2000, LAT_ERET)};
        vecs[5] = '{s: mkS(K_ERET, 32'h3, 0, 0, 0, 32'h4440, 32'h9990),
                    r: mkR(1, 1, 1, 12, 32'h1, 0, 0, 0, 0, 32'h4440, LAT_ERET)};
        vecs[6] = '{s: mkS(K_EXC, 32'h0, 12, 32'h500, 6'h21, 0, 0),
                    r: mkR(1, 1, 3, 14, 32'h500, 13, 32'h8430, 12, 32'h2, 32'h3000, LAT_ENTRY)};
        vecs[7] = '{s: mkS(K_EXC, 32'h4, 10, 32'h600, 0, 0, 0),
                    r: mkR(1, 1, 3, 14, 32'h600, 13, 32'h28, 12, 32'h6, 32'h3000, LAT_ENTRY)};

        // Reset state: every output low while reset is held.
        #2;
        check("reset.trap_ack", 64'(trapAck), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.redirect", {31'b0, redirectValid, redirectPc}, 64'd0);
        check("reset.flush", 64'(flush), 64'd0);
        check("reset.cp0_port", {20'b0, cpIf.cp0_num, cpIf.cp0_sel, cpIf.cp0_wdata,
                                 cpIf.cp0_wr, cpIf.cp0_rd, cpIf.cp0_op}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle pass-through: background STATUS read, then a pipeline mfc0 of EPC.
        pipeWrite(14, 32'hCAFE_0000);
        #1;
        check("idle.status_read", {56'b0, cpIf.cp0_num, cpIf.cp0_rd, cpIf.cp0_wr, 1'b0},
              {56'b0, 5'd12, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        pipeNum = 5'd14; pipeRd = 1'b1;
        #1;
        check("mfc0.port", {56'b0, cpIf.cp0_num, cpIf.cp0_rd, cpIf.cp0_wr, 1'b0},
              {56'b0, 5'd14, 1'b1, 1'b0, 1'b0});
        check("mfc0.rdata", 64'(pipeRdata), 64'h0000_0000_CAFE_0000);
        @(negedge clk);
        pipeNum = '0; pipeRd = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].s, obs);
            checkOutput($sformatf("vec%0d", i), vecs[i].r, obs);
        end

        // Exception and eret together: exception first, eret stays pending and follows.
        pipeWrite(12, 32'h1);
        @(negedge clk);
        excValid = 1'b1; excCode = 5'd8; excPc = 32'h700; eretValid = 1'b1;
        #1;
        check("both.exc_ack", 64'(trapAck), 64'd1);
        @(negedge clk);
        excValid = 1'b0;
        waitSig(0, 8, found, cnt);
        check("both.exc_redirect_seen", 64'(found), 64'd1);
        check("both.exc_redirect_pc", 64'(redirectPc), 64'h3000);
        @(negedge clk);
        waitSig(1, 4, found, cnt);
        check("both.eret_ack_seen", 64'(found), 64'd1);
        check("both.eret_ack_cycle", 64'(cnt), 64'd0);
        @(negedge clk);
        eretValid = 1'b0;
        waitSig(0, 6, found, cnt);
        check("both.eret_redirect_seen", 64'(found), 64'd1);
        check("both.eret_redirect_pc", 64'(redirectPc), 64'h700);
        check("both.status_after", 64'(cp0Regs[{5'd12, 3'd0}]), 64'h1);
        repeat (2) @(negedge clk);

        // Reset during T_CAUSE: outputs drop at once, the EPC write already made stays.
        pipeWrite(14, 32'h0);
        pipeWrite(12, 32'h1);
        @(negedge clk);
        causeBefore = cp0Regs[{5'd13, 3'd0}];
        excValid = 1'b1; excCode = 5'd12; excPc = 32'h900;
        #1;
        check("rstmid.ack", 64'(trapAck), 64'd1);
        @(negedge clk);
        excValid = 1'b0;
        @(negedge clk);
        #1;
        check("rstmid.in_cause", {56'b0, busy, cpIf.cp0_wr, cpIf.cp0_num, 1'b0},
              {56'b0, 1'b1, 1'b1, 5'd13, 1'b0});
        rst = 1'b1;
        #1;
        check("rstmid.outputs", {27'b0, busy, trapAck, flush, redirectValid, cpIf.cp0_wr,
                                 cpIf.cp0_rd, cpIf.cp0_num, cpIf.cp0_wdata[23:0]}, 64'd0);
        check("rstmid.epc_kept", 64'(cp0Regs[{5'd14, 3'd0}]), 64'h900);
        check("rstmid.cause_kept", 64'(cp0Regs[{5'd13, 3'd0}]), 64'(causeBefore));
        check("rstmid.status_kept", 64'(cp0Regs[{5'd12, 3'd0}]), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(vecs[0].s, obs);
        checkOutput("restart", vecs[0].r, obs);

        // Randomized traps against the reference model.
        for (int i = 0; i < 40; i++) begin
            s.kind   = int'($urandom_range(0, 2));
            s.status = $urandom & 32'h0040_FC07;
            s.code   = codes[$urandom_range(0, 3)];
            s.pc     = $urandom & 32'hFFFF_FFFC;
            s.intReq = (s.kind == K_ERET) ? 6'd0 : 6'($urandom_range(0, 63));
            s.epcPre = $urandom & 32'hFFFF_FFFC;
            s.errPre = $urandom & 32'hFFFF_FFFC;
            exp = predict(s);
            applyStimulus(s, obs);
            checkOutput($sformatf("rnd%0d", i), exp, obs);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
